bus_scheduler: RTL and testbench

Shares the single bus transaction engine (enable / 2-bit status / 8-bit received data) between N_REQ software requesters. Arbitration is round-robin. The block forwards the winner's command byte and pulses the engine's enable. It then tracks status through to OK or CRC error, retries on CRC error, and returns data plus a response code to the winning requester. It sits between the register/software interface and the bus control engine.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/bus_scheduler.sv | 132 +++++++++++++
 tb/tb_bus_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus scheduler: sequencing states, engine status
// encodings and response codes returned to requesters.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      ACCEPT,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] ST_TX  = 2'd0;
   localparam logic [1:0] ST_RX  = 2'd1;
   localparam logic [1:0] ST_OK  = 2'd2;
   localparam logic [1:0] ST_CRC = 2'd3;

   localparam logic [1:0] RSP_OK      = 2'd0;
   localparam logic [1:0] RSP_CRC     = 2'd1;
   localparam logic [1:0] RSP_TIMEOUT = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around to bit 0.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       ptr,
   output logic             vld,
   output logic [2:0]       idx
);

   logic [N_REQ-1:0] rot;
   logic [3:0]       sum;

   always_comb begin
      // Rotate so bit 0 of rot is requester ptr; the lowest set bit wins.
      rot = N_REQ'({req, req} >> ptr);
      vld = |req;
      sum = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) sum = {1'b0, ptr} + 4'(i);
      end
      if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
      idx = sum[2:0];
   end

endmodule

// File: rtl/bus_scheduler.sv
// Round-robin sharing of one bus transaction engine between N_REQ requesters,
// with CRC retry, per-attempt timeout and a one-hot completion pulse.
module bus_scheduler #(
   parameter int N_REQ     = 4,
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 1023,
   parameter int TO_W      = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_cmd,
   output logic [N_REQ-1:0]   done,
   output logic [7:0]         rsp_data,
   output logic [1:0]         rsp_err,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               ctrl_enable,
   output logic [7:0]         ctrl_cmd,
   input  logic [1:0]         ctrl_status,
   input  logic [7:0]         ctrl_data
);
   import bus_pkg::*;

   state_t            state;
   logic [2:0]        rr_ptr;
   logic [2:0]        retry_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              arb_vld;
   logic [2:0]        arb_idx;
   logic [7:0]        sel_cmd;
   logic [N_REQ-1:0]  grant_oh;
   logic [2:0]        ptr_nx;
   logic              to_hit;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req (req),
      .ptr (rr_ptr),
      .vld (arb_vld),
      .idx (arb_idx)
   );

   always_comb begin
      sel_cmd  = '0;
      grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_idx == 3'(i)) sel_cmd = req_cmd[i*8 +: 8];
         grant_oh[i] = (grant_id == 3'(i));
      end
      ptr_nx = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
      to_hit = (to_cnt == TO_W'(TIMEOUT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         retry_cnt   <= '0;
         to_cnt      <= '0;
         done        <= '0;
         rsp_data    <= '0;
         rsp_err     <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
         ctrl_enable <= 1'b0;
         ctrl_cmd    <= '0;
      end else begin
         ctrl_enable <= 1'b0;
         done        <= '0;
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  grant_id    <= arb_idx;
                  ctrl_cmd    <= sel_cmd;
                  retry_cnt   <= '0;
                  busy        <= 1'b1;
                  ctrl_enable <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               to_cnt <= '0;
               state  <= ACCEPT;
            end
            ACCEPT: begin
               if (to_hit) begin
                  rsp_err <= RSP_TIMEOUT;
                  done    <= grant_oh;
                  state   <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  // Leftover OK/CRC from a previous attempt must not count as acceptance.
                  if (ctrl_status == ST_TX || ctrl_status == ST_RX) state <= WAIT;
               end
            end
            WAIT: begin
               if (to_hit) begin
                  rsp_err <= RSP_TIMEOUT;
                  done    <= grant_oh;
                  state   <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (ctrl_status == ST_OK) begin
                     rsp_data <= ctrl_data;
                     rsp_err  <= RSP_OK;
                     done     <= grant_oh;
                     state    <= DONE;
                  end else if (ctrl_status == ST_CRC) begin
                     if (retry_cnt < 3'(MAX_RETRY)) begin
                        retry_cnt   <= retry_cnt + 3'd1;
                        ctrl_enable <= 1'b1;
                        state       <= ISSUE;
                     end else begin
                        rsp_data <= ctrl_data;
                        rsp_err  <= RSP_CRC;
                        done     <= grant_oh;
                        state    <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               busy   <= 1'b0;
               rr_ptr <= ptr_nx;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_scheduler.sv
// Bench for bus_scheduler: behavioural engine, expected completions queued at
// request time and checked against each done pulse.
module tb_bus_scheduler;

   localparam int N_REQ = 4;

   logic               clock;
   logic               reset;
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_cmd;
   logic [N_REQ-1:0]   done;
   logic [7:0]         rsp_data;
   logic [1:0]         rsp_err;
   logic               busy;
   logic [2:0]         grant_id;
   logic               ctrl_enable;
   logic [7:0]         ctrl_cmd;
   logic [1:0]         ctrl_status;
   logic [7:0]         ctrl_data;

   bus_scheduler #(.N_REQ(N_REQ), .MAX_RETRY(2), .TIMEOUT(20), .TO_W(10)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_cmd     (req_cmd),
      .done        (done),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .grant_id    (grant_id),
      .ctrl_enable (ctrl_enable),
      .ctrl_cmd    (ctrl_cmd),
      .ctrl_status (ctrl_status),
      .ctrl_data   (ctrl_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] dn;
      logic [2:0] gid;
      logic [7:0] cmd;
      logic [7:0] data;
      logic [1:0] err;
      int         en;
      bit         chk_to;
   } exp_t;

   typedef struct {
      logic [3:0] req;
      logic [2:0] gid;
      logic [7:0] cmd;
      int         mode;     // 0 ok, 1 one CRC then ok, 2 always CRC, 3 hang
      logic [7:0] eng_data;
      logic [7:0] exp_data;
      logic [1:0] exp_err;
      int         exp_en;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   int         eng_mode = 0;
   int         eng_crc_left = 0;
   logic [7:0] eng_data = 8'h00;
   bit         phase = 0;
   int         cnt = 0;
   int         en_count = 0;
   int         cyc = 0;
   int         last_en_cyc = 0;

   task automatic chk(input string name, input int act, input int req_v);
      total++;
      if (act != req_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req_v, $time);
      end
   endtask

   // Completion monitor followed by the engine model, both on the falling edge.
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         phase       = 0;
         cnt         = 0;
         en_count    = 0;
         ctrl_status = 2'd2;
      end else begin
         if (done != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", int'(done), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done", int'(done), int'(e.dn));
               chk("grant_id", int'(grant_id), int'(e.gid));
               chk("ctrl_cmd", int'(ctrl_cmd), int'(e.cmd));
               chk("rsp_data", int'(rsp_data), int'(e.data));
               chk("rsp_err", int'(rsp_err), int'(e.err));
               chk("busy_at_done", int'(busy), 1);
               chk("enables", en_count, e.en);
               if (e.chk_to) chk("timeout_latency", cyc - last_en_cyc, 22);
            end
            en_count = 0;
         end
         if (ctrl_enable) begin
            en_count++;
            last_en_cyc = cyc;
            phase = 1;
            cnt = 0;
         end else if (phase) begin
            cnt++;
            if (cnt == 1) ctrl_status = 2'd0;
            if (cnt == 3) ctrl_status = 2'd1;
            if (cnt == 5) begin
               case (eng_mode)
                  0: begin ctrl_status = 2'd2; ctrl_data = eng_data; phase = 0; end
                  1: begin
                     if (eng_crc_left > 0) begin
                        ctrl_status = 2'd3; ctrl_data = 8'hEE; eng_crc_left--;
                     end else begin
                        ctrl_status = 2'd2; ctrl_data = eng_data;
                     end
                     phase = 0;
                  end
                  2: begin ctrl_status = 2'd3; ctrl_data = eng_data; phase = 0; end
                  default: ;
               endcase
            end
         end
      end
   end

   task automatic wait_done(input int bound);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done == '0 && n < bound);
      if (done == '0) begin
         total++;
         bad++;
         $display("FAIL wait_done: no done within %0d cycles", bound);
      end
   endtask

   task automatic push(input logic [3:0] dn, input logic [2:0] gid, input logic [7:0] cmd,
                       input logic [7:0] data, input logic [1:0] err, input int en, input bit to);
      exp_t e;
      e.dn = dn; e.gid = gid; e.cmd = cmd; e.data = data; e.err = err; e.en = en; e.chk_to = to;
      sb.push_back(e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_rsp_data"}, int'(rsp_data), 0);
      chk({tag, "_rsp_err"}, int'(rsp_err), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_grant_id"}, int'(grant_id), 0);
      chk({tag, "_ctrl_enable"}, int'(ctrl_enable), 0);
      chk({tag, "_ctrl_cmd"}, int'(ctrl_cmd), 0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{4'b0001, 3'd0, 8'hA5, 0, 8'h3C, 8'h3C, 2'd0, 1};
      vecs[1] = '{4'b0100, 3'd2, 8'h5A, 1, 8'h77, 8'h77, 2'd0, 2};
      vecs[2] = '{4'b1000, 3'd3, 8'hC3, 2, 8'h99, 8'h99, 2'd1, 3};
      vecs[3] = '{4'b0010, 3'd1, 8'h11, 3, 8'h44, 8'h99, 2'd2, 1};
      vecs[4] = '{4'b0001, 3'd0, 8'h22, 0, 8'h00, 8'h00, 2'd0, 1};

      reset = 1'b1; req = '0; req_cmd = '0; ctrl_status = 2'd2; ctrl_data = 8'h00;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 5; i++) begin
         eng_mode = vecs[i].mode;
         eng_crc_left = 1;
         eng_data = vecs[i].eng_data;
         req_cmd[vecs[i].gid*8 +: 8] = vecs[i].cmd;
         push(vecs[i].req, vecs[i].gid, vecs[i].cmd, vecs[i].exp_data,
              vecs[i].exp_err, vecs[i].exp_en, vecs[i].exp_err == 2'd2);
         req = vecs[i].req;
         wait_done(100);
         req = '0;
         @(negedge clock);
         chk("busy_after_done", int'(busy), 0);
      end

      // Round-robin from a fresh pointer with requesters 0, 1 and 3 held.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      eng_mode = 0;
      eng_data = 8'h5E;
      req_cmd = {8'h43, 8'h32, 8'h21, 8'h10};
      push(4'b0001, 3'd0, 8'h10, 8'h5E, 2'd0, 1, 0);
      push(4'b0010, 3'd1, 8'h21, 8'h5E, 2'd0, 1, 0);
      push(4'b1000, 3'd3, 8'h43, 8'h5E, 2'd0, 1, 0);
      push(4'b0001, 3'd0, 8'h10, 8'h5E, 2'd0, 1, 0);
      req = 4'b1011;
      for (int k = 0; k < 4; k++) wait_done(100);
      req = '0;
      repeat (2) @(negedge clock);

      // Asynchronous reset while the engine is stuck mid-transaction.
      eng_mode = 3;
      req_cmd[7:0] = 8'hF0;
      req = 4'b0001;
      repeat (8) @(negedge clock);
      chk("busy_mid_wait", int'(busy), 1);
      @(posedge clock);
      #2 reset = 1'b1;
      req = '0;
      #1 chk_all_zero("async_reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      eng_mode = 0;
      eng_data = 8'hD2;
      req_cmd[23:16] = 8'h6B;
      push(4'b0100, 3'd2, 8'h6B, 8'hD2, 2'd0, 1, 0);
      req = 4'b0100;
      wait_done(100);
      req = '0;
      repeat (3) @(negedge clock);

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
